// File: rtl/pipe_check_pkg.sv
// Shared definitions for the BTPipe pattern generator/checker.
// Holds mode encodings, LFSR tap positions, default seed and LFSR step.
package pipe_check_pkg;

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'b00,
        MODE_LFSR    = 2'b01,
        MODE_WALK    = 2'b10,
        MODE_ALT     = 2'b11
    } mode_e;

    // Fibonacci taps 32,22,2,1 expressed as zero-based bit positions
    localparam int LFSR_TAP_A = 31;
    localparam int LFSR_TAP_B = 21;
    localparam int LFSR_TAP_C = 1;
    localparam int LFSR_TAP_D = 0;

    localparam logic [31:0] DEFAULT_SEED = 32'h0D0C0B0A;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0],
                s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
    endfunction

endpackage

// File: rtl/pipe_pattern_gen.sv
// Pattern state machine: holds the current word of the selected sequence
// and steps once per advance. Ports: clk, reset, mode, advance, word.
module pipe_pattern_gen
    import pipe_check_pkg::*;
#(
    parameter int          DATA_W = 16,
    parameter logic [31:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              advance,
    output logic [DATA_W-1:0] word
);

    mode_e       mode_q;
    logic [31:0] lfsr;
    logic [31:0] lfsr_nxt;
    logic [DATA_W-1:0] word_nxt;

    function automatic logic [DATA_W-1:0] first_word(input mode_e m);
        logic [DATA_W-1:0] w;
        w = DATA_W'(1);
        unique case (m)
            MODE_COUNTER: w = DATA_W'(1);
            MODE_LFSR:    w = SEED[DATA_W-1:0];
            MODE_WALK:    w = DATA_W'(1);
            MODE_ALT:     w = {(DATA_W/2){2'b01}};
        endcase
        return w;
    endfunction

    always_comb begin
        lfsr_nxt = lfsr_step(lfsr);
        word_nxt = word;
        unique case (mode_q)
            MODE_COUNTER: word_nxt = word + DATA_W'(1);
            MODE_LFSR:    word_nxt = lfsr_nxt[DATA_W-1:0];
            MODE_WALK:    word_nxt = {word[DATA_W-2:0], word[DATA_W-1]};
            MODE_ALT:     word_nxt = ~word;
        endcase
    end

    // Mode is latched only during reset; later changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= mode_e'(mode);
            lfsr   <= SEED;
            word   <= first_word(mode_e'(mode));
        end else if (advance) begin
            lfsr   <= lfsr_nxt;
            word   <= word_nxt;
        end
    end

endmodule

// File: rtl/pipe_check_gen.sv
// BTPipe traffic engine: generator drives PipeOut, checker verifies PipeIn.
// Ports: clk/reset, mode, throttle, PipeIn/PipeOut strobes+data, status.
module pipe_check_gen
    import pipe_check_pkg::*;
#(
    parameter int          DATA_W = 16,
    parameter int          ERR_W  = 16,
    parameter int          CNT_W  = 32,
    parameter logic [31:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [3:0]        throttle,
    input  logic              in_write,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              out_read,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [ERR_W-1:0]  error_count,
    output logic [CNT_W-1:0]  rx_words,
    output logic [CNT_W-1:0]  tx_words,
    output logic              first_err_valid,
    output logic [CNT_W-1:0]  first_err_index,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act
);

    logic [DATA_W-1:0] exp_word;
    logic              mismatch;
    logic [3:0]        phase;
    logic [3:0]        phase_nxt;
    logic              ready;

    pipe_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_gen (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .advance (out_read),
        .word    (out_data)
    );

    pipe_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_chk (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .advance (in_write),
        .word    (exp_word)
    );

    assign mismatch  = in_write && (in_data != exp_word);
    assign phase_nxt = phase + 4'd1;
    assign in_ready  = ready;
    assign out_valid = ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase           <= 4'd0;
            ready           <= 1'b1;
            error_count     <= '0;
            rx_words        <= '0;
            tx_words        <= '0;
            first_err_valid <= 1'b0;
            first_err_index <= '0;
            first_err_exp   <= '0;
            first_err_act   <= '0;
        end else begin
            // ready registered against the phase it will accompany
            phase <= phase_nxt;
            ready <= (phase_nxt >= throttle);
            if (out_read)
                tx_words <= tx_words + CNT_W'(1);
            if (in_write)
                rx_words <= rx_words + CNT_W'(1);
            if (mismatch) begin
                if (error_count != {ERR_W{1'b1}})
                    error_count <= error_count + ERR_W'(1);
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_index <= rx_words;
                    first_err_exp   <= exp_word;
                    first_err_act   <= in_data;
                end
            end
        end
    end

endmodule

// File: doc/pipe_check_gen.md
# pipe_check_gen

Parametrised pipe traffic engine for Opal Kelly BTPipe benchmarking and integrity testing. It has one pattern generator feeding the PipeOut datapath and one independent pattern checker consuming the PipeIn datapath. It supports selectable patterns, programmable ready throttling, a saturating error counter, word counters and first-error capture. It sits between the okBTPipeIn/okBTPipeOut endpoints and the WireIn/WireOut control/status endpoints, clocked by ti_clk.

## Interface
- DATA_W, 16: pipe word width; legal values 16 or 32.
- ERR_W, 16: error counter width.
- CNT_W, 32: word counter and index width.
- SEED, 32'h0D0C0B0A: LFSR reset value; must be non-zero.

Ports (clock and reset first):
- clk  in  1  ti_clk domain; single clock.
- reset  in  1  synchronous, active-high.
- mode  in  2  00 counter, 01 LFSR, 10 walking-one, 11 alternating 0x55../0xAA..; sampled only while reset=1.
- throttle  in  4  ready/valid duty control, 0 = always.
- in_write  in  1  PipeIn write strobe.
- in_data  in  DATA_W  PipeIn data.
- in_ready  out  1  PipeIn block ready.
- out_read  in  1  PipeOut read strobe.
- out_data  out  DATA_W  PipeOut data.
- out_valid  out  1  PipeOut block ready.
- error_count  out  ERR_W  saturating mismatch count.
- rx_words  out  CNT_W  words received, wraps.
- tx_words  out  CNT_W  words sent, wraps.
- first_err_valid  out  1  sticky; high once a mismatch has been recorded.
- first_err_index  out  CNT_W  rx_words value at the first mismatch.
- first_err_exp  out  DATA_W  expected word at the first mismatch.
- first_err_act  out  DATA_W  received word at the first mismatch.

## Operation
- Generator and checker are identical pattern state machines. Each advances one step per accepted word:
  - out_read=1 advances the generator.
  - in_write=1 advances the checker.
- Pattern sequences (the first word of each sequence is listed first):
  - Counter: 1, 2, 3, … wraps 2^DATA_W−1 → 0.
  - LFSR: 32-bit Fibonacci, taps 32,22,2,1. The new bit is lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0], shifted in at bit 0. The word is lfsr[DATA_W-1:0]. The first word is SEED[DATA_W-1:0].
  - Walking-one: 1, then rotate left by 1; bit DATA_W−1 → bit 0.
  - Alternating: 0x5555…, 0xAAAA…, repeat.
- Checker compares in_data with the expected word on each in_write.
  - On mismatch, error_count increments, saturating at 2^ERR_W−1.
  - On the first mismatch only, first_err_index, first_err_exp and first_err_act are loaded and first_err_valid is set.
- rx_words and tx_words increment per accepted word and wrap at 2^CNT_W.
- Throttle uses a 4-bit free-running phase counter, reset to 0, incrementing every cycle.
  - in_ready and out_valid are registered and equal (phase >= throttle).
  - throttle=0 means always high; throttle=15 means high 1 of 16 cycles.
- Strobes are honoured regardless of in_ready/out_valid; ready/valid are advisory block-level signals, per BTPipe semantics.
- A mode change without reset has no effect.

## Timing
- Reset values:
  - error_count, rx_words, tx_words, first_err_* are 0.
  - in_ready and out_valid are 1 in the first cycle after reset.
  - out_data is the first pattern word.
- out_data is registered. After a cycle with out_read=1, the next word appears on the following cycle. Back-to-back reads yield consecutive words with no bubble.
- Checker compare, counter update and capture take effect at the clock edge of the in_write cycle; outputs are visible the next cycle.
- Counter wrap: word 0xFFFF (DATA_W=16) is followed by 0x0000.
- Simultaneous in_write and out_read: both engines advance independently in the same cycle.
- Mismatch while error_count is saturated: the count holds and the capture registers are unchanged.
- Reset mid-transfer overrides any strobe in the same cycle. All state returns to its reset values, and the next accepted word is the first word of the newly sampled mode.

## Structure
- Package pipe_check_pkg holds:
  - mode encodings (MODE_COUNTER, MODE_LFSR, MODE_WALK, MODE_ALT);
  - the LFSR tap constants;
  - the default SEED.
- Sub-module pipe_pattern_gen (parameter DATA_W, SEED; ports clk, reset, mode, advance, word) is instantiated twice: once as generator, once as expected-value source for the checker.
- Top level adds the compare logic, counters, capture registers and throttle phase counter.

## Test plan
- Counter mode, DATA_W=16, 3 reads after reset → out_data 0x0001, 0x0002, 0x0003, 0x0004; tx_words=3.
- Counter mode, loop out_data → in_data for 70000 words → wrap passes, error_count=0, rx_words=70000, first_err_valid=0.
- LFSR mode, SEED default, loop back 4096 words with word index 5 XOR 0x0001 → error_count=1, first_err_index=5, first_err_exp ^ first_err_act = 0x0001.
- ERR_W=4, alternating mode, 20 all-zero writes → error_count saturates at 15; first_err_index=0, first_err_exp=0x5555.
- throttle=3 over 32 cycles → in_ready and out_valid high 26 cycles, low on phases 0–2.
- Walking-one, assert reset with out_read=1 after 7 reads, mode set to 00 → next out_data=0x0001, tx_words=0; mode 10 ignored if changed later without reset.
